// File: rtl/cpu_program_loader.sv
// Boot/run controller: streams a program into instruction memory while the
// CPU is held in reset, then releases it for a programmed number of cycles.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   load_valid/ready/data program byte stream (valid/ready handshake)
//   start, run_cycles     launch reset-hold/run; run length (0 = free-run)
//   abort, clear          end RUN early; discard program and flags
//   imem_we/addr/wdata    registered instruction-memory write port
//   cpu_reset, cpu_hold   CPU reset and freeze controls
//   busy, done, error     status (HOLD|RUN, DONE, sticky start-rejected)
//   prog_len, cycle_count bytes loaded, RUN cycles elapsed
module cpu_program_loader #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int RUN_W      = 16,
   parameter int RST_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   input  logic              start,
   input  logic [RUN_W-1:0]  run_cycles,
   input  logic              abort,
   input  logic              clear,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_reset,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   prog_len,
   output logic [RUN_W-1:0]  cycle_count
);

   typedef enum logic [1:0] {
      S_LOAD,
      S_HOLD,
      S_RUN,
      S_DONE
   } state_t;

   localparam int HOLD_W =
      (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST =
      HOLD_W'(RST_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE = 1;
   localparam logic [RUN_W-1:0]  CNT_MAX  = '1;
   localparam logic [RUN_W-1:0]  CNT_ONE  = 1;
   localparam logic [ADDR_W:0]   LEN_ONE  = 1;

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W:0]     r_prog_len;
   logic [RUN_W-1:0]    r_run;
   logic [RUN_W-1:0]    r_count;
   logic [HOLD_W-1:0]   r_hold;
   logic                r_error;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;

   logic                w_full;
   logic                w_len_ok;
   logic                w_accept;
   logic [RUN_W-1:0]    w_count_inc;
   logic                w_run_end;
   logic                w_launch;

   // Memory is full once prog_len reaches 2^ADDR_W (only the MSB set).
   assign w_full   = r_prog_len[ADDR_W];
   // Instructions are 16 bits: a runnable program is non-empty and even.
   assign w_len_ok = (r_prog_len != '0) && !r_prog_len[0];

   assign load_ready = (r_state == S_LOAD) && !w_full
                       && !start && !clear;
   assign w_accept   = load_valid && load_ready;

   // Saturating increment keeps a free-running count from wrapping.
   assign w_count_inc = (r_count == CNT_MAX) ? r_count
                                              : r_count + CNT_ONE;
   assign w_run_end   = ((r_run != '0) && (w_count_inc == r_run))
                        || abort;

   assign w_launch = !clear && start
                     && (((r_state == S_LOAD) && w_len_ok)
                         || (r_state == S_DONE));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (clear) begin
         w_next = S_LOAD;
      end else begin
         unique case (r_state)
            S_LOAD: if (start && w_len_ok) w_next = S_HOLD;
            S_HOLD: if (r_hold == HOLD_LAST) w_next = S_RUN;
            S_RUN:  if (w_run_end) w_next = S_DONE;
            S_DONE: if (start) w_next = S_HOLD;
            default: w_next = S_LOAD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prog_len <= '0;
         r_run      <= '0;
         r_count    <= '0;
         r_hold     <= '0;
         r_error    <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_we <= w_accept;
         if (w_accept) begin
            r_addr  <= r_prog_len[ADDR_W-1:0];
            r_wdata <= load_data;
         end
         if (clear) begin
            r_prog_len <= '0;
            r_count    <= '0;
            r_error    <= 1'b0;
         end else begin
            if (w_accept) begin
               r_prog_len <= r_prog_len + LEN_ONE;
            end
            if ((r_state == S_LOAD) && start && !w_len_ok) begin
               r_error <= 1'b1;
            end
            if (w_launch) begin
               r_run   <= run_cycles;
               r_count <= '0;
               r_hold  <= '0;
            end else if (r_state == S_HOLD) begin
               r_hold <= r_hold + HOLD_ONE;
            end else if (r_state == S_RUN) begin
               r_count <= w_count_inc;
            end
         end
      end
   end

   assign imem_we     = r_we;
   assign imem_addr   = r_addr;
   assign imem_wdata  = r_wdata;
   assign cpu_reset   = (r_state == S_LOAD) || (r_state == S_HOLD);
   assign cpu_hold    = (r_state != S_RUN);
   assign busy        = (r_state == S_HOLD) || (r_state == S_RUN);
   assign done        = (r_state == S_DONE);
   assign error       = r_error;
   assign prog_len    = r_prog_len;
   assign cycle_count = r_count;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Self-checking bench for cpu_program_loader (ADDR_W=3, RUN_W=4).
// Reference model plus directed literal checks.
module tb_cpu_program_loader;

   localparam int AW  = 3;
   localparam int DW  = 8;
   localparam int RW  = 4;
   localparam int RC  = 2;
   localparam int CAP = 1 << AW;
   localparam int CMAX = (1 << RW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic [DW-1:0] load_data = '0;
   logic          start = 1'b0;
   logic [RW-1:0] run_cycles = '0;
   logic          abort = 1'b0;
   logic          clear = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_wdata;
   logic          cpu_reset;
   logic          cpu_hold;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW:0]   prog_len;
   logic [RW-1:0] cycle_count;

   cpu_program_loader #(
      .ADDR_W(AW), .DATA_W(DW), .RUN_W(RW), .RST_CYCLES(RC)
   ) dut (
      .clk(clk), .reset(rst_n),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .start(start),
      .run_cycles(run_cycles), .abort(abort), .clear(clear),
      .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
      .cpu_hold(cpu_hold), .busy(busy), .done(done),
      .error(error), .prog_len(prog_len),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   // Instruction memory as seen by the CPU.
   logic [DW-1:0] mem [CAP];
   always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;

   // Reference model: phase of the sequence plus counters.
   localparam int ML = 0, MH = 1, MR = 2, MD = 3;
   int m_st, m_len, m_cnt, m_run, m_holdleft;
   int m_addr, m_wdata;
   bit m_err, m_we, acc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st = ML; m_len = 0; m_cnt = 0; m_run = 0;
         m_holdleft = 0; m_err = 0; m_we = 0;
      end else begin
         acc = (m_st == ML) && (m_len < CAP) && !start
               && !clear && load_valid;
         m_we = acc;
         if (acc) begin
            m_addr = m_len; m_wdata = load_data;
            m_len++;
         end
         if (clear) begin
            m_st = ML; m_len = 0; m_cnt = 0; m_err = 0;
         end else if ((m_st == ML || m_st == MD) && start) begin
            if (m_st == ML && (m_len == 0 || m_len % 2 == 1)) begin
               m_err = 1;
            end else begin
               m_run = run_cycles; m_cnt = 0;
               m_holdleft = RC; m_st = MH;
            end
         end else if (m_st == MH) begin
            m_holdleft--;
            if (m_holdleft == 0) m_st = MR;
         end else if (m_st == MR) begin
            if (m_cnt < CMAX) m_cnt++;
            if ((m_run != 0 && m_cnt == m_run) || abort) m_st = MD;
         end
      end
   end

   bit cmp_en = 0;
   int hold_seen = 0;
   int run_seen = 0;

   always @(negedge clk) begin
      if (cpu_reset && busy) hold_seen++;
      if (!cpu_reset && !cpu_hold) run_seen++;
      if (cmp_en) begin
         chk("load_ready", load_ready,
             (m_st == ML) && (m_len < CAP) && !start && !clear);
         chk("imem_we", imem_we, m_we);
         if (m_we) begin
            chk("imem_addr", imem_addr, m_addr);
            chk("imem_wdata", imem_wdata, m_wdata);
         end
         chk("cpu_reset", cpu_reset, m_st == ML || m_st == MH);
         chk("cpu_hold", cpu_hold, m_st != MR);
         chk("busy", busy, m_st == MH || m_st == MR);
         chk("done", done, m_st == MD);
         chk("error", error, m_err);
         chk("prog_len", prog_len, m_len);
         chk("cycle_count", cycle_count, m_cnt);
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic load_byte(input logic [7:0] b);
      load_valid = 1; load_data = b; tick;
      load_valid = 0;
   endtask

   task automatic pulse_start(input int rc);
      run_cycles = RW'(rc); start = 1; tick; start = 0;
   endtask

   task automatic do_clear;
      clear = 1; tick; clear = 0;
   endtask

   task automatic wait_done(input string nm);
      for (int i = 0; i < 60 && !done; i++) tick;
      chk(nm, done, 1);
   endtask

   logic [7:0] prog6 [6] = '{8'h84, 8'h0A, 8'h88,
                             8'h14, 8'h0D, 8'h28};

   initial begin
      #1 rst_n = 0;
      #2;
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_cpu_hold", cpu_hold, 1);
      chk("rst_load_ready", load_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_prog_len", prog_len, 0);
      cmp_en = 1;
      tick; tick;
      rst_n = 1;
      tick;

      // Six-byte program, run 10 cycles.
      for (int i = 0; i < 6; i++) load_byte(prog6[i]);
      hold_seen = 0; run_seen = 0;
      pulse_start(10);
      wait_done("t1_done");
      chk("t1_prog_len", prog_len, 6);
      chk("t1_cycle_count", cycle_count, 10);
      chk("t1_hold_cycles", hold_seen, 2);
      chk("t1_run_cycles", run_seen, 10);
      for (int i = 0; i < 6; i++) chk("t1_mem", mem[i], prog6[i]);

      // Odd length rejected.
      do_clear;
      load_byte(8'h01); load_byte(8'h02); load_byte(8'h03);
      pulse_start(4);
      tick;
      chk("t2_error", error, 1);
      chk("t2_cpu_reset", cpu_reset, 1);
      chk("t2_busy", busy, 0);
      do_clear;
      chk("t2_clr_error", error, 0);
      chk("t2_clr_len", prog_len, 0);

      // Full memory: nine bytes with valid held high.
      load_valid = 1;
      for (int i = 0; i < 9; i++) begin
         load_data = 8'hA0 + 8'(i); tick;
      end
      load_valid = 0;
      tick;
      chk("t3_prog_len", prog_len, 8);
      chk("t3_load_ready", load_ready, 0);
      chk("t3_mem0", mem[0], 8'hA0);
      chk("t3_mem7", mem[7], 8'hA7);

      // Free-run saturation, then abort.
      pulse_start(0);
      repeat (20) tick;
      abort = 1; tick; abort = 0;
      chk("t4_done", done, 1);
      chk("t4_sat", cycle_count, CMAX);

      // Rerun from DONE, abort on 5th RUN cycle.
      pulse_start(0);
      chk("t5_restart_cnt", cycle_count, 0);
      chk("t5_restart_busy", busy, 1);
      tick; tick;
      repeat (4) tick;
      abort = 1; tick; abort = 0;
      chk("t5_done", done, 1);
      chk("t5_cnt", cycle_count, 5);
      pulse_start(0);
      chk("t5_rerun_cnt", cycle_count, 0);
      chk("t5_rerun_reset", cpu_reset, 1);
      repeat (4) tick;
      abort = 1; tick; abort = 0;
      chk("t5_rerun_cnt2", cycle_count, 3);

      // Start and byte in the same cycle.
      do_clear;
      load_byte(8'h11); load_byte(8'h22);
      load_valid = 1; load_data = 8'h33;
      run_cycles = 3; start = 1;
      #1 chk("t6_ready_low", load_ready, 0);
      tick;
      load_valid = 0; start = 0;
      chk("t6_prog_len", prog_len, 2);
      chk("t6_busy", busy, 1);
      tick;
      chk("t6_mem2", mem[2], 8'hA2);
      wait_done("t6_done");
      chk("t6_cnt", cycle_count, 3);

      // Asynchronous reset in the middle of RUN.
      pulse_start(10);
      repeat (5) tick;
      chk("t7_in_run", cpu_hold, 0);
      @(negedge clk); #2;
      rst_n = 0;
      #1;
      chk("t7_cpu_reset", cpu_reset, 1);
      chk("t7_cpu_hold", cpu_hold, 1);
      chk("t7_busy", busy, 0);
      chk("t7_done", done, 0);
      chk("t7_cnt", cycle_count, 0);
      chk("t7_len", prog_len, 0);
      chk("t7_ready", load_ready, 1);
      chk("t7_we", imem_we, 0);
      tick;
      rst_n = 1;
      tick; tick;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/cpu_program_loader.md
# cpu_program_loader

Synthesisable boot and run controller for the single-cycle CPU. It accepts a program as a byte stream over a valid/ready handshake and writes it into instruction memory while the CPU is held in reset. On start, it releases the CPU for a programmed number of cycles, then stops and reports completion. It sits between a host or debug interface and `top_cpu`, and replaces hand-written memory preloads with a reusable, parametrised load/run sequence.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory byte address width; capacity 2^ADDR_W bytes
- DATA_W, 8, instruction-memory word width
- RUN_W, 16, run-cycle counter width
- RST_CYCLES, 2, cycles the CPU reset is held after start (minimum 1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  one clock; reset is asynchronous and active-low
- load_valid  in  1  program byte present
- load_ready  out  1  byte accepted when valid & ready
- load_data  in  DATA_W  program byte
- start  in  1  begin reset-hold/run sequence
- run_cycles  in  RUN_W  run length, sampled on start; 0 = free-run
- abort  in  1  end RUN early
- clear  in  1  discard program and flags, return to LOAD
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  DATA_W  write data
- cpu_reset  out  1  active-high reset to top_cpu
- cpu_hold  out  1  active-high freeze for CPU PC/register-file enable
- busy  out  1  high in HOLD and RUN
- done  out  1  high in DONE
- error  out  1  sticky start-rejected flag
- prog_len  out  ADDR_W+1  bytes loaded
- cycle_count  out  RUN_W  RUN cycles elapsed

## Operation
- FSM states: LOAD (reset state), HOLD, RUN, DONE.
- LOAD:
  - cpu_reset=1, cpu_hold=1.
  - load_ready = !full & !start & !clear, where full means prog_len == 2^ADDR_W.
  - On an accepted byte, write it at address prog_len, then increment prog_len.
  - On start, with clear low:
    - If prog_len is 0 or odd (instructions are 16-bit), set error and stay in LOAD.
    - Otherwise latch run_cycles, zero cycle_count and the hold counter, and go to HOLD.
- HOLD: cpu_reset=1, cpu_hold=1 for exactly RST_CYCLES cycles, then go to RUN.
- RUN:
  - cpu_reset=0, cpu_hold=0.
  - cycle_count increments every cycle.
  - Go to DONE when the incremented count equals the latched run_cycles (if nonzero), or when abort is high.
  - With run_cycles=0, cycle_count saturates at all-ones and never wraps.
- DONE:
  - cpu_reset=0, cpu_hold=1, so CPU state stays visible.
  - start goes to HOLD again, rerunning the same program. run_cycles is re-sampled and cycle_count is zeroed.
  - load_valid is ignored (load_ready=0).
- clear, in any state: go to LOAD, zero prog_len, cycle_count and error. clear has priority over start, abort and load.
- Instruction-memory contents are not erased by clear; they are overwritten by the next load.
- Asynchronous reset while reset is low, in any state including mid-RUN:
  - State LOAD.
  - prog_len, cycle_count, imem_we, imem_addr, imem_wdata, error, busy, done all 0.
  - cpu_reset=1, cpu_hold=1, load_ready=1.

## Timing
- Handshake completes on a rising edge when load_valid & load_ready are both high.
- imem_we, imem_addr and imem_wdata are registered: they are asserted for one cycle after the accepting edge, so the memory writes on the following edge.
- prog_len updates on the accepting edge.
- load_valid may be held high; back-to-back bytes are accepted one per cycle.
- cpu_reset, cpu_hold, busy and done are decoded from the state register, so they are glitch-free and change on the edge that changes state.
- Start at edge N: cpu_reset stays 1 through cycle N+RST_CYCLES-1, and RUN covers cycles N+RST_CYCLES through N+RST_CYCLES+run_cycles-1. The CPU therefore executes exactly run_cycles rising edges with cpu_reset=0 and cpu_hold=0.
- abort sampled high in RUN at edge M: state is DONE after M, and cycle_count includes cycle M.
- error, once set, stays high until clear or reset.

## Test plan
- Six-byte program and normal run:
  - Stimulus: load 84,0A,88,14,0D,28, then start with run_cycles=10.
  - Required: imem writes at addresses 0..5 carry those bytes, prog_len=6, cpu_reset is high for 2 cycles after start and then low for exactly 10 cycles, done=1, cycle_count=10.
- Odd length:
  - Stimulus: load 3 bytes, then start.
  - Required: error=1, state remains LOAD with cpu_reset=1. A following clear gives error=0, prog_len=0.
- Full memory (ADDR_W=3):
  - Stimulus: stream 9 bytes with load_valid held high.
  - Required: 8 bytes accepted, load_ready=0 thereafter, prog_len=8, no write to address 0 on the 9th byte.
- Free-run, abort and rerun:
  - Stimulus: run_cycles=0, start, abort on the 5th RUN cycle; then start again.
  - Required: after the abort, state is DONE with cycle_count=5. The second start reruns from HOLD with cycle_count restarting at 0.
- Simultaneous start and byte:
  - Stimulus: start and load_valid high in the same cycle with even prog_len.
  - Required: load_ready=0 that cycle, the byte is not written, and the state moves to HOLD.
- Asynchronous reset mid-RUN:
  - Stimulus: drive reset low between clock edges during RUN.
  - Required: cpu_reset=1 immediately, without waiting for an edge, and all outputs at their reset values.
